race_scheduler: RTL and testbench

- Game-flow controller for the car game: owns the police and coin obstacle positions, advances them once per frame tick and respawns them at pseudo-random columns.
- Consumes the single-cycle CoinEn/PoliceEn hit pulses from the hit detector to update score and lives.
- Sequences IDLE / PLAY / HIT_PAUSE / GAME_OVER.
- Outputs drive the hit detector (positions) and the renderer (positions, score, lives, status).

---
 rtl/race_scheduler.sv | 167 ++++++++++++++++
 tb/tb_race_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/race_scheduler.sv
// Game-flow controller for the car game: frame timing, obstacle movement and
// respawn, score/lives bookkeeping and the IDLE/PLAY/HIT_PAUSE/GAME_OVER sequence.
module race_scheduler #(
  parameter int unsigned FRAME_DIV   = 833333,
  parameter logic [6:0]  Y_MAX       = 7'd119,
  parameter logic [4:0]  X_MAX       = 5'd27,
  parameter logic [6:0]  PO_STEP     = 7'd2,
  parameter logic [6:0]  COIN_STEP   = 7'd1,
  parameter logic [1:0]  START_LIVES = 2'd3,
  parameter logic [5:0]  PAUSE_TICKS = 6'd30
) (
  input  logic       CLOCK_50,
  input  logic [0:0] KEY,
  input  logic       EnterEn,
  input  logic       CoinEn,
  input  logic       PoliceEn,
  output logic [4:0] x_po,
  output logic [6:0] y_po,
  output logic [4:0] x_coin,
  output logic [6:0] y_coin,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       frame_tick,
  output logic       playing,
  output logic       game_over,
  output logic [1:0] dbg_state
);

  // EnterEn, CoinEn and PoliceEn are single-cycle pulses with no back-pressure:
  // a pulse is acted on in the cycle it is high, or dropped if the state ignores it.

  localparam int unsigned    CW       = $clog2(FRAME_DIV);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FRAME_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_lfsr;
  logic [5:0]    r_pause;
  logic          r_coin_pend;

  logic       w_fb;
  logic [4:0] w_c;
  logic [4:0] w_spawn;
  logic [7:0] w_po_adv;
  logic [7:0] w_coin_adv;
  logic       w_po_wrap;
  logic       w_coin_wrap;

  assign w_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_c     = r_lfsr[4:0];
  assign w_spawn = (w_c <= X_MAX) ? w_c : (w_c - (X_MAX + 5'd1));

  // Advance in 8 bits so a row near Y_MAX cannot wrap before the compare.
  assign w_po_adv    = {1'b0, y_po}   + {1'b0, PO_STEP};
  assign w_coin_adv  = {1'b0, y_coin} + {1'b0, COIN_STEP};
  assign w_po_wrap   = (w_po_adv   > {1'b0, Y_MAX});
  assign w_coin_wrap = (w_coin_adv > {1'b0, Y_MAX});

  assign dbg_state = r_state;

  always_ff @(posedge CLOCK_50) begin
    if (!KEY[0]) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_lfsr      <= 8'hA5;
      r_pause     <= '0;
      r_coin_pend <= 1'b0;
      x_po        <= 5'd0;
      y_po        <= 7'd0;
      x_coin      <= 5'd14;
      y_coin      <= 7'd0;
      score       <= 8'd0;
      lives       <= START_LIVES;
      frame_tick  <= 1'b0;
      playing     <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      r_cnt       <= (r_cnt == CNT_LAST) ? '0 : (r_cnt + CW'(1));
      frame_tick  <= (r_cnt == CNT_LAST);
      r_lfsr      <= {r_lfsr[6:0], w_fb};
      r_coin_pend <= 1'b0;

      // Coin column is drawn one cycle after the police column at game start.
      if (r_coin_pend) x_coin <= w_spawn;

      case (r_state)
        S_IDLE, S_OVER: begin
          if (EnterEn) begin
            r_state     <= S_PLAY;
            playing     <= 1'b1;
            game_over   <= 1'b0;
            score       <= 8'd0;
            lives       <= START_LIVES;
            y_po        <= 7'd0;
            y_coin      <= 7'd0;
            x_po        <= w_spawn;
            r_coin_pend <= 1'b1;
          end
        end

        S_PLAY: begin
          if (frame_tick) begin
            if (w_po_wrap) begin
              y_po <= 7'd0;
              x_po <= w_spawn;
            end else begin
              y_po <= w_po_adv[6:0];
            end
            if (w_coin_wrap) begin
              y_coin <= 7'd0;
              x_coin <= w_spawn;
            end else begin
              y_coin <= w_coin_adv[6:0];
            end
          end
          // Hit respawns come after the tick so they override its advance.
          if (CoinEn) begin
            score  <= (score == 8'hFF) ? score : (score + 8'd1);
            y_coin <= 7'd0;
            x_coin <= w_spawn;
          end
          if (PoliceEn) begin
            y_po <= 7'd0;
            x_po <= w_spawn;
            if (lives <= 2'd1) begin
              lives     <= 2'd0;
              r_state   <= S_OVER;
              playing   <= 1'b0;
              game_over <= 1'b1;
            end else begin
              lives   <= lives - 2'd1;
              r_state <= S_PAUSE;
              playing <= 1'b0;
              r_pause <= PAUSE_TICKS;
            end
          end
        end

        S_PAUSE: begin
          if (frame_tick) begin
            if (r_pause <= 6'd1) begin
              r_state <= S_PLAY;
              playing <= 1'b1;
              r_pause <= 6'd0;
            end else begin
              r_pause <= r_pause - 6'd1;
            end
          end
        end

        default: begin
          r_state   <= S_IDLE;
          playing   <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_race_scheduler.sv
// Bench for race_scheduler: two instances (Y_MAX=119 and Y_MAX=19), directed
// stimulus pushing expected values into a queue, a monitor popping them by cycle.
module tb_race_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [0:0] key1, key2;
  logic enter1, coin1, pol1, enter2, coin2, pol2;
  logic [4:0] x_po1, x_coin1, x_po2, x_coin2;
  logic [6:0] y_po1, y_coin1, y_po2, y_coin2;
  logic [7:0] score1, score2;
  logic [1:0] lives1, lives2, st1, st2;
  logic tick1, tick2, play1, play2, go1, go2;

  race_scheduler #(.FRAME_DIV(4), .PAUSE_TICKS(6'd2)) u_dut1 (
    .CLOCK_50(clk), .KEY(key1), .EnterEn(enter1), .CoinEn(coin1), .PoliceEn(pol1),
    .x_po(x_po1), .y_po(y_po1), .x_coin(x_coin1), .y_coin(y_coin1),
    .score(score1), .lives(lives1), .frame_tick(tick1), .playing(play1),
    .game_over(go1), .dbg_state(st1)
  );

  race_scheduler #(.FRAME_DIV(4), .PAUSE_TICKS(6'd2), .Y_MAX(7'd19)) u_dut2 (
    .CLOCK_50(clk), .KEY(key2), .EnterEn(enter2), .CoinEn(coin2), .PoliceEn(pol2),
    .x_po(x_po2), .y_po(y_po2), .x_coin(x_coin2), .y_coin(y_coin2),
    .score(score2), .lives(lives2), .frame_tick(tick2), .playing(play2),
    .game_over(go2), .dbg_state(st2)
  );

  // Signal ids
  localparam int XPO = 0, YPO = 1, XCO = 2, YCO = 3, SCO = 4, LIV = 5, TCK = 6,
                 PLY = 7, GOV = 8, STA = 9, D2 = 10;
  string nm [0:19] = '{"x_po1", "y_po1", "x_coin1", "y_coin1", "score1", "lives1",
                       "tick1", "playing1", "game_over1", "state1",
                       "x_po2", "y_po2", "x_coin2", "y_coin2", "score2", "lives2",
                       "tick2", "playing2", "game_over2", "state2"};

  typedef struct {
    int         due;
    int         id;
    logic [7:0] val;
  } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [7:0] m1;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [7:0] spawn(input logic [7:0] l);
    logic [4:0] c;
    c = l[4:0];
    return (c <= 5'd27) ? {3'b000, c} : {3'b000, c - 5'd28};
  endfunction

  function automatic logic [7:0] get_act(input int id);
    case (id)
      0:  return {3'b0, x_po1};
      1:  return {1'b0, y_po1};
      2:  return {3'b0, x_coin1};
      3:  return {1'b0, y_coin1};
      4:  return score1;
      5:  return {6'b0, lives1};
      6:  return {7'b0, tick1};
      7:  return {7'b0, play1};
      8:  return {7'b0, go1};
      9:  return {6'b0, st1};
      10: return {3'b0, x_po2};
      11: return {1'b0, y_po2};
      12: return {3'b0, x_coin2};
      13: return {1'b0, y_coin2};
      14: return score2;
      15: return {6'b0, lives2};
      16: return {7'b0, tick2};
      17: return {7'b0, play2};
      18: return {7'b0, go2};
      default: return {6'b0, st2};
    endcase
  endfunction

  // Independent LFSR reference for instance 1
  always @(posedge clk) m1 <= (!key1[0]) ? 8'hA5 : lfsr_step(m1);

  // Monitor: compares every queued expectation that falls due this cycle
  initial begin
    exp_t e;
    logic [7:0] a;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        a = get_act(e.id);
        checks = checks + 1;
        if (a !== e.val) begin
          errors = errors + 1;
          $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm[e.id], a, e.val, cyc);
        end
      end
    end
  end

  task automatic push_exp(input int id, input logic [7:0] v, input int lat);
    exp_q.push_back('{cyc + lat, id, v});
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic timeout_fail(input string what);
    checks = checks + 1;
    errors = errors + 1;
    $display("FAIL %s: wait expired, got 0 expected 1", what);
  endtask

  task automatic wait_tick1();
    int k;
    k = 0;
    while (!tick1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!tick1) timeout_fail("wait_tick1");
  endtask

  task automatic wait_play2();
    int k;
    k = 0;
    while (!play2 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!play2) timeout_fail("wait_play2");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lf, lf_pol;
    int k;
    key1 = 1'b0; key2 = 1'b0;
    enter1 = 0; coin1 = 0; pol1 = 0; enter2 = 0; coin2 = 0; pol2 = 0;
    nclk(3);

    // Reset values
    push_exp(XPO, 8'd0, 1);  push_exp(YPO, 8'd0, 1);  push_exp(XCO, 8'd14, 1);
    push_exp(YCO, 8'd0, 1);  push_exp(SCO, 8'd0, 1);  push_exp(LIV, 8'd3, 1);
    push_exp(TCK, 8'd0, 1);  push_exp(PLY, 8'd0, 1);  push_exp(GOV, 8'd0, 1);
    push_exp(STA, 8'd0, 1);
    nclk(1);
    key1 = 1'b1; key2 = 1'b1;

    // Start both games right on a tick so the next advance is 4 cycles later
    wait_tick1();
    lf = m1;
    enter1 = 1; enter2 = 1;
    push_exp(PLY, 8'd1, 1);  push_exp(SCO, 8'd0, 1);  push_exp(LIV, 8'd3, 1);
    push_exp(YPO, 8'd0, 1);  push_exp(YCO, 8'd0, 1);  push_exp(GOV, 8'd0, 1);
    push_exp(XPO, spawn(lf), 1);
    push_exp(D2 + PLY, 8'd1, 1); push_exp(D2 + XPO, spawn(lf), 1);
    push_exp(XCO, spawn(lfsr_step(lf)), 2);
    push_exp(D2 + XCO, spawn(lfsr_step(lf)), 2);
    push_exp(TCK, 8'd1, 4);  push_exp(TCK, 8'd0, 5);  push_exp(TCK, 8'd0, 6);
    push_exp(TCK, 8'd0, 7);  push_exp(TCK, 8'd1, 8);
    push_exp(D2 + YPO, 8'd18, 37);
    push_exp(YPO, 8'd20, 41); push_exp(YCO, 8'd10, 41); push_exp(XPO, spawn(lf), 41);
    push_exp(D2 + YCO, 8'd10, 41); push_exp(D2 + YPO, 8'd0, 41);
    nclk(1);
    enter1 = 0; enter2 = 0;
    nclk(39);
    // Tenth tick wraps instance 2's police and draws a fresh column
    push_exp(D2 + XPO, spawn(m1), 1);
    nclk(2);

    // Non-fatal police hit, then a pause of two ticks
    lf_pol = m1;
    pol1 = 1;
    push_exp(LIV, 8'd2, 1); push_exp(YPO, 8'd0, 1); push_exp(XPO, spawn(lf_pol), 1);
    push_exp(PLY, 8'd0, 1); push_exp(YCO, 8'd10, 1); push_exp(STA, 8'd2, 1);
    nclk(1);
    pol1 = 0;
    nclk(2);
    coin1 = 1; pol1 = 1;
    push_exp(SCO, 8'd0, 1); push_exp(YCO, 8'd10, 1); push_exp(LIV, 8'd2, 1);
    nclk(1);
    coin1 = 0; pol1 = 0;
    push_exp(PLY, 8'd0, 1);
    push_exp(PLY, 8'd1, 3); push_exp(YPO, 8'd0, 3); push_exp(YCO, 8'd10, 3);
    push_exp(YPO, 8'd2, 7); push_exp(YCO, 8'd11, 7); push_exp(XPO, spawn(lf_pol), 7);
    nclk(7);

    // Score saturation
    for (int i = 1; i <= 256; i++) begin
      coin1 = 1;
      push_exp(SCO, (i > 255) ? 8'd255 : 8'(i), 1);
      push_exp(YCO, 8'd0, 1);
      nclk(1);
    end
    coin1 = 0;
    push_exp(SCO, 8'd255, 1);
    nclk(1);

    // Instance 2: lose two lives, then a simultaneous coin and fatal police hit
    for (int j = 0; j < 2; j++) begin
      pol2 = 1;
      push_exp(D2 + LIV, 8'(2 - j), 1); push_exp(D2 + PLY, 8'd0, 1);
      push_exp(D2 + STA, 8'd2, 1);
      nclk(1);
      pol2 = 0;
      wait_play2();
    end
    coin2 = 1; pol2 = 1;
    push_exp(D2 + SCO, 8'd1, 1); push_exp(D2 + LIV, 8'd0, 1);
    push_exp(D2 + GOV, 8'd1, 1); push_exp(D2 + PLY, 8'd0, 1);
    push_exp(D2 + STA, 8'd3, 1);
    nclk(1);
    coin2 = 0; pol2 = 0;
    nclk(2);
    coin2 = 1; pol2 = 1;
    push_exp(D2 + SCO, 8'd1, 1); push_exp(D2 + LIV, 8'd0, 1); push_exp(D2 + GOV, 8'd1, 1);
    nclk(1);
    coin2 = 0; pol2 = 0;
    nclk(2);
    enter2 = 1;
    push_exp(D2 + PLY, 8'd1, 1); push_exp(D2 + SCO, 8'd0, 1); push_exp(D2 + LIV, 8'd3, 1);
    push_exp(D2 + GOV, 8'd0, 1); push_exp(D2 + YPO, 8'd0, 1); push_exp(D2 + YCO, 8'd0, 1);
    nclk(1);
    enter2 = 0;
    nclk(1);

    // Collect 7 coins, then reset mid-game
    for (int i = 1; i <= 7; i++) begin
      coin2 = 1;
      push_exp(D2 + SCO, 8'(i), 1);
      nclk(1);
    end
    coin2 = 0;
    push_exp(D2 + SCO, 8'd7, 1);
    nclk(1);
    key2 = 1'b0;
    push_exp(D2 + STA, 8'd0, 1); push_exp(D2 + SCO, 8'd0, 1); push_exp(D2 + LIV, 8'd3, 1);
    push_exp(D2 + PLY, 8'd0, 1); push_exp(D2 + GOV, 8'd0, 1); push_exp(D2 + TCK, 8'd0, 1);
    push_exp(D2 + XPO, 8'd0, 1); push_exp(D2 + YPO, 8'd0, 1); push_exp(D2 + XCO, 8'd14, 1);
    push_exp(D2 + YCO, 8'd0, 1);
    nclk(1);
    key2 = 1'b1;
    coin2 = 1; pol2 = 1;
    push_exp(D2 + SCO, 8'd0, 1); push_exp(D2 + LIV, 8'd3, 1); push_exp(D2 + STA, 8'd0, 1);
    push_exp(D2 + XCO, 8'd14, 1); push_exp(D2 + XPO, 8'd0, 1);
    nclk(1);
    coin2 = 0; pol2 = 0;
    // LFSR restarted at A5: one step gives 4A (column 10), the next 95 (column 21)
    enter2 = 1;
    push_exp(D2 + PLY, 8'd1, 1); push_exp(D2 + XPO, 8'd10, 1);
    push_exp(D2 + XCO, 8'd21, 2);
    nclk(1);
    enter2 = 0;
    nclk(3);

    k = 0;
    while (exp_q.size() > 0 && k < 100) begin
      nclk(1);
      k++;
    end
    if (exp_q.size() > 0) begin
      $display("FAIL leftover: got %0d pending expected 0", exp_q.size());
      checks = checks + exp_q.size();
      errors = errors + exp_q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
